// File: rtl/sram_pkg.sv
// ============================================================================
// Module      : sram_pkg
// Description : Shared defaults and helpers for the SRAM FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

  localparam int DEF_RAM_WIDTH = 8;
  localparam int DEF_RAM_DEPTH = 64;
  localparam int DEF_ADDR_SIZE = 8;

  // Width of an occupancy counter able to hold 0..depth inclusive
  function automatic int COUNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_fifo_ptr.sv
// ============================================================================
// Module      : sram_fifo_ptr
// Description : Address pointer that advances on inc and wraps from
//               RAM_DEPTH-1 back to 0 by explicit compare, so non power-of-2
//               depths work.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_fifo_ptr
  import sram_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [ADDR_SIZE-1:0] ptr
);

  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(RAM_DEPTH - 1);

  logic [ADDR_SIZE-1:0] ptr_d;
  logic [ADDR_SIZE-1:0] ptr_q;

  // Next pointer: hold, increment, or wrap at the last valid entry
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      if (ptr_q == LAST) ptr_d = '0;
      else               ptr_d = ptr_q + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/sram_fifo_ctrl.sv
// ============================================================================
// Module      : sram_fifo_ctrl
// Description : FIFO controller driving an external dual-port SRAM. Port A
//               writes, port B reads (one-cycle synchronous). Provides
//               registered occupancy flags, a count and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_fifo_ctrl
  import sram_pkg::*;
#(
  parameter int RAM_WIDTH = DEF_RAM_WIDTH,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int AF_LEVEL  = 60,
  parameter int AE_LEVEL  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [RAM_WIDTH-1:0]             wr_data,
  input  logic                             rd_en,
  output logic [RAM_WIDTH-1:0]             rd_data,
  output logic                             rd_valid,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic [COUNT_W(RAM_DEPTH)-1:0]    count,
  output logic                             overflow,
  output logic                             underflow,
  output logic [RAM_WIDTH-1:0]             sram_data_A,
  output logic [ADDR_SIZE-1:0]             sram_addr_A,
  output logic                             sram_rwenable_A,
  output logic [RAM_WIDTH-1:0]             sram_data_B,
  output logic [ADDR_SIZE-1:0]             sram_addr_B,
  output logic                             sram_rwenable_B,
  input  logic [RAM_WIDTH-1:0]             sram_outputData_B
);

  localparam int CW = COUNT_W(RAM_DEPTH);

  logic                 wr_acc;
  logic                 rd_acc;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;

  logic [CW-1:0] count_d,        count_q;
  logic          full_d,         full_q;
  logic          empty_d,        empty_q;
  logic          almost_full_d,  almost_full_q;
  logic          almost_empty_d, almost_empty_q;
  logic          rd_valid_d,     rd_valid_q;
  logic          overflow_d,     overflow_q;
  logic          underflow_d,    underflow_q;

  // Accepts are gated by the registered flags so a rejected request never
  // touches the pointers, the count or the SRAM ports.
  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;

  sram_fifo_ptr #(
    .ADDR_SIZE (ADDR_SIZE),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  sram_fifo_ptr #(
    .ADDR_SIZE (ADDR_SIZE),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  // Next count, flags derived from the next count, and sticky error flags
  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d         = (count_d == CW'(RAM_DEPTH));
    empty_d        = (count_d == '0);
    almost_full_d  = (int'(count_d) >= AF_LEVEL);
    almost_empty_d = (int'(count_d) <= AE_LEVEL);
    rd_valid_d     = rd_acc;
    overflow_d     = overflow_q  | (wr_en & full_q);
    underflow_d    = underflow_q | (rd_en & empty_q);
  end

  // State registers; reset also kills any read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      rd_valid_q     <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      rd_valid_q     <= rd_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign sram_rwenable_A = wr_acc;
  assign sram_addr_A     = wr_ptr;
  assign sram_data_A     = wr_data;
  assign sram_rwenable_B = 1'b0;
  assign sram_addr_B     = rd_ptr;
  assign sram_data_B     = '0;

  assign rd_data      = sram_outputData_B;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
// ============================================================================
// Module      : tb_sram_fifo_ctrl
// Description : Self-checking bench for sram_fifo_ctrl with behavioural SRAMs
//               (depth 64 instance and depth 48 instance for wrap-around).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_fifo_ctrl;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  // ---------------- depth-64 instance ----------------
  logic       wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic [6:0] count;
  logic       overflow, underflow;
  logic [7:0] sdata_a, sdata_b, sq_b;
  logic [7:0] saddr_a, saddr_b;
  logic       swe_a, swe_b;
  logic [7:0] mem64 [256];

  sram_fifo_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .rd_en             (rd_en),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .full              (full),
    .empty             (empty),
    .almost_full       (almost_full),
    .almost_empty      (almost_empty),
    .count             (count),
    .overflow          (overflow),
    .underflow         (underflow),
    .sram_data_A       (sdata_a),
    .sram_addr_A       (saddr_a),
    .sram_rwenable_A   (swe_a),
    .sram_data_B       (sdata_b),
    .sram_addr_B       (saddr_b),
    .sram_rwenable_B   (swe_b),
    .sram_outputData_B (sq_b)
  );

  always @(posedge clk) begin
    if (swe_a) mem64[saddr_a] <= sdata_a;
    sq_b <= mem64[saddr_b];
  end

  // ---------------- depth-48 instance ----------------
  logic       b_wr, b_rd;
  logic [7:0] b_wd, b_rdat;
  logic       b_rv, b_full, b_empty, b_af, b_ae;
  logic [5:0] b_count;
  logic       b_ovf, b_udf;
  logic [7:0] b_sdata_a, b_sdata_b, b_sq_b;
  logic [7:0] b_saddr_a, b_saddr_b;
  logic       b_swe_a, b_swe_b;
  logic [7:0] mem48 [256];

  sram_fifo_ctrl #(.RAM_DEPTH(48), .AF_LEVEL(44), .AE_LEVEL(4)) dut48 (
    .clk               (clk),
    .reset             (reset),
    .wr_en             (b_wr),
    .wr_data           (b_wd),
    .rd_en             (b_rd),
    .rd_data           (b_rdat),
    .rd_valid          (b_rv),
    .full              (b_full),
    .empty             (b_empty),
    .almost_full       (b_af),
    .almost_empty      (b_ae),
    .count             (b_count),
    .overflow          (b_ovf),
    .underflow         (b_udf),
    .sram_data_A       (b_sdata_a),
    .sram_addr_A       (b_saddr_a),
    .sram_rwenable_A   (b_swe_a),
    .sram_data_B       (b_sdata_b),
    .sram_addr_B       (b_saddr_b),
    .sram_rwenable_B   (b_swe_b),
    .sram_outputData_B (b_sq_b)
  );

  always @(posedge clk) begin
    if (b_swe_a) mem48[b_saddr_a] <= b_sdata_a;
    b_sq_b <= mem48[b_saddr_b];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    int         cnt;
    logic       emp;
    logic       ae;
    logic       rv;
    logic [7:0] rdat;
  } vec_t;

  vec_t       vecs [12];
  logic [7:0] q [$];
  logic [7:0] exp_b;
  logic [7:0] addr_snap;
  logic [7:0] prev_addr;
  logic       saw_wrap;

  initial begin
    tests = 0;
    fails = 0;

    //            wr  wd     rd cnt emp ae rv rdat
    vecs[0]  = '{1'b1, 8'd16, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 8'd17, 1'b0, 2, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 8'd18, 1'b0, 3, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 8'd19, 1'b0, 4, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 8'd0,  1'b1, 3, 1'b0, 1'b1, 1'b1, 8'd16};
    vecs[5]  = '{1'b0, 8'd0,  1'b1, 2, 1'b0, 1'b1, 1'b1, 8'd17};
    vecs[6]  = '{1'b0, 8'd0,  1'b1, 1, 1'b0, 1'b1, 1'b1, 8'd18};
    vecs[7]  = '{1'b0, 8'd0,  1'b1, 0, 1'b1, 1'b1, 1'b1, 8'd19};
    vecs[8]  = '{1'b1, 8'd5,  1'b0, 1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 8'd6,  1'b1, 1, 1'b0, 1'b1, 1'b1, 8'd5};
    vecs[10] = '{1'b0, 8'd0,  1'b1, 0, 1'b1, 1'b1, 1'b1, 8'd6};
    vecs[11] = '{1'b0, 8'd0,  1'b0, 0, 1'b1, 1'b1, 1'b0, 8'd0};

    reset = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'd0;
    b_wr = 1'b0;  b_rd = 1'b0;  b_wd = 8'd0;
    saw_wrap = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset then idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      chk("idle_empty", empty, 1);
      chk("idle_ae",    almost_empty, 1);
      chk("idle_count", count, 0);
      chk("idle_rv",    rd_valid, 0);
      chk("idle_we_a",  swe_a, 0);
      tick();
    end

    // Table-driven push/pop vectors
    for (int i = 0; i < 12; i++) begin
      wr_en = vecs[i].wr; wr_data = vecs[i].wd; rd_en = vecs[i].rd;
      tick();
      chk("vec_count", count, vecs[i].cnt);
      chk("vec_empty", empty, vecs[i].emp);
      chk("vec_ae",    almost_empty, vecs[i].ae);
      chk("vec_rv",    rd_valid, vecs[i].rv);
      if (vecs[i].rv) chk("vec_rdata", rd_data, vecs[i].rdat);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Fill to 64
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_af",    almost_full, (i + 1 >= 60));
      chk("fill_full",  full, (i + 1 == 64));
      chk("fill_ae",    almost_empty, (i + 1 <= 4));
    end

    // 65th push is rejected
    wr_en = 1'b1; wr_data = 8'hEE;
    #1;
    chk("ovf_we_a", swe_a, 0);
    tick();
    chk("ovf_count", count, 64);
    chk("ovf_flag",  overflow, 1);
    chk("ovf_full",  full, 1);

    // Full: simultaneous push/pop -> only the pop is accepted
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hDD;
    tick();
    chk("fullrw_count", count, 63);
    chk("fullrw_full",  full, 0);
    chk("fullrw_rv",    rd_valid, 1);
    chk("fullrw_data",  rd_data, 0);

    // Drain in order
    wr_en = 1'b0;
    for (int j = 1; j < 64; j++) begin
      tick();
      chk("drain_rv",   rd_valid, 1);
      chk("drain_data", rd_data, j);
    end
    rd_en = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_empty", empty, 1);
    chk("ovf_sticky",  overflow, 1);

    // Empty: simultaneous push/pop -> only the push is accepted
    chk("udf_pre", underflow, 0);
    addr_snap = saddr_b;
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h42;
    tick();
    chk("udf_flag",  underflow, 1);
    chk("udf_rv",    rd_valid, 0);
    chk("udf_addrb", saddr_b, addr_snap);
    chk("udf_count", count, 1);
    wr_en = 1'b0;
    tick();
    chk("udf_pop_rv",   rd_valid, 1);
    chk("udf_pop_data", rd_data, 8'h42);
    chk("udf_pop_cnt",  count, 0);
    rd_en = 1'b0;
    repeat (3) tick();
    chk("udf_sticky", underflow, 1);

    // Wrap-around on the depth-48 instance at steady count 10
    for (int i = 0; i < 10; i++) begin
      b_wr = 1'b1; b_wd = 8'(100 + i);
      q.push_back(b_wd);
      tick();
    end
    chk("wrap_prime", b_count, 10);
    for (int k = 0; k < 200; k++) begin
      b_wr = 1'b1; b_rd = 1'b1; b_wd = 8'(110 + k);
      q.push_back(b_wd);
      prev_addr = b_saddr_a;
      tick();
      chk("wrap_count", b_count, 10);
      chk("wrap_rv", b_rv, 1);
      if (b_rv) begin
        exp_b = q.pop_front();
        chk("wrap_data", b_rdat, exp_b);
      end
      if (prev_addr == 8'd47) begin
        chk("wrap_addr", b_saddr_a, 0);
        saw_wrap = 1'b1;
      end
    end
    b_wr = 1'b0; b_rd = 1'b0;
    chk("wrap_seen", saw_wrap, 1);

    // Reset with a pop in flight
    wr_en = 1'b1; wr_data = 8'd1;
    tick();
    wr_data = 8'd2;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("rst_pre_rv", rd_valid, 1);
    reset = 1'b1;
    #1;
    chk("rst_rv",    rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae",    almost_empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_af",    almost_full, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_udf",   underflow, 0);
    chk("rst_addra", saddr_a, 0);
    chk("rst_addrb", saddr_b, 0);
    #3 reset = 1'b0;
    tick();
    chk("post_rst_empty", empty, 1);
    chk("post_rst_rv",    rd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
